module_rx_buffer_ctrl: RTL and testbench
========================================

Name: module_rx_buffer_ctrl

Overview:
Parametrised successor to the single-byte UART RX handshake FSM. It detects a received word (rx_data_rdy), captures rx_data_i into an internal first-word-fall-through (FWFT) FIFO, and pulses the control write strobe. It then holds the receiver's clear request for a configurable number of cycles and waits for the ready flag to drop before re-arming. Sits between the UART receiver and the control/register block, so a consumer can drain bursts of received words at its own pace.

Parameters:
DATA_W, 8, width of received word and FIFO entry
DEPTH, 16, FIFO entries; power of two, >= 2
CLEAR_CYCLES, 1, cycles new_rx_clear stays high after the capture cycle; >= 1

Ports:
clk_i  input  1  system clock, rising edge
reset_i  input  1  asynchronous, active-low reset
rx_data_rdy  input  1  receiver flag: word available on rx_data_i
rx_data_i  input  DATA_W  received word, stable while rx_data_rdy high
new_rx_clear  output  1  request to receiver to clear rx_data_rdy
we_control_rx_o  output  1  one-cycle strobe: word captured (pushed or dropped)
rd_en_i  input  1  consumer pop request
rd_data_o  output  DATA_W  FIFO head (FWFT)
empty_o  output  1  FIFO holds 0 entries
full_o  output  1  FIFO holds DEPTH entries
count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow_o  output  1  sticky: a captured word was dropped
ovf_clr_i  input  1  clears overflow_o

Behaviour:
- Reset (async assert, sync release on clk_i): state S_IDLE; FIFO pointers and count 0; empty_o=1; full_o=0; count_o=0; overflow_o=0; new_rx_clear=0; we_control_rx_o=0; rd_data_o=0. FIFO storage is not reset. Reset mid-operation aborts any capture/clear sequence immediately, and all FIFO contents are lost.
- FSM, registered state, Moore outputs:
  - S_IDLE: outputs 0. rx_data_rdy=1 -> S_CAPTURE; else stay.
  - S_CAPTURE (1 cycle): we_control_rx_o=1, new_rx_clear=1. Push attempt of rx_data_i at the end of this cycle. Load the clear counter with CLEAR_CYCLES. -> S_CLEAR.
  - S_CLEAR: new_rx_clear=1. Decrement the counter each cycle. Counter reaching 1 -> S_RELEASE.
  - S_RELEASE: outputs 0. rx_data_rdy=0 -> S_IDLE; else stay. A flag stuck high never causes a second capture.
  - Unreachable encodings -> S_IDLE with outputs 0.
- Timing with CLEAR_CYCLES=1: rdy sampled high at edge N. we_control_rx_o and new_rx_clear are high in cycle N+1. new_rx_clear is high in cycle N+2. The earliest next capture strobe is cycle N+5 (IDLE at N+3 if rdy low, CAPTURE at N+4 edge). new_rx_clear is high for exactly 1+CLEAR_CYCLES cycles per word.
- FIFO:
  - Circular buffer with $clog2(DEPTH)-bit pointers; pointers wrap DEPTH-1 -> 0.
  - Push accepted if count_o < DEPTH, or if a pop occurs in the same cycle.
  - Pop accepted if rd_en_i=1 and count_o > 0. rd_en_i while empty is ignored, with no pointer or count change.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance. When full, the pop frees the slot the push uses.
  - rd_data_o = mem[rd_ptr] when count_o > 0, else 0. It updates the cycle after a pop, or after a push into an empty FIFO (write-then-visible, 1-cycle latency).
  - full_o = (count_o==DEPTH); empty_o = (count_o==0). Both are derived from the registered count.
- Overflow: a push attempt in S_CAPTURE while full with no same-cycle pop drops the word; no state change. overflow_o goes high on the next edge and stays high until ovf_clr_i=1. If set and clear occur in the same cycle, set wins.
- ovf_clr_i has no effect on the FIFO or the FSM.

Test Plan:
- Single word: reset, rx_data_i=0xA5, rdy high for 1 cycle -> we_control_rx_o pulses once; new_rx_clear high 2 cycles; count_o=1; rd_data_o=0xA5; pop -> empty_o=1, rd_data_o=0.
- Stuck flag and CLEAR_CYCLES=3: hold rdy high 20 cycles -> exactly one strobe; new_rx_clear high 4 cycles; FSM stays in S_RELEASE until rdy drops; next rdy pulse is captured.
- Fill and overflow, DEPTH=4: capture 0x01..0x05 without popping -> full_o=1 after the 4th, 5th dropped, overflow_o=1, count_o=4. Drain -> 0x01..0x04 in order. ovf_clr_i -> overflow_o=0.
- Full with simultaneous pop: FIFO full with 0x10..0x13; rd_en_i=1 in the same cycle as the capture of 0x14 -> overflow_o stays 0, count_o=4, drain order 0x11..0x14.
- Wrap-around: DEPTH=4; 10 push/pop interleavings with values 0x20..0x29 -> data order preserved, count_o never exceeds 4, rd_en_i while empty causes no change.
- Async reset mid-sequence: assert reset_i low during S_CLEAR with count_o=2 -> outputs go to reset values immediately, without a clock edge. After release, FSM is in S_IDLE, empty_o=1, and the next rdy pulse is captured normally.

Source files
------------

// File: rtl/module_rx_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : module_rx_buffer_ctrl
// Purpose  : UART RX handshake controller with an internal first-word-fall-
//            through FIFO. Each word flagged by rx_data_rdy is captured once
//            (pushed, or dropped when the FIFO is full). The receiver is then
//            asked to clear its flag for 1+CLEAR_CYCLES cycles. The next
//            capture is armed only after the flag has dropped.
// Ports    : clk_i           - system clock, rising edge
//            reset_i         - asynchronous active-low reset
//            rx_data_rdy     - receiver flag: word available on rx_data_i
//            rx_data_i       - received word
//            new_rx_clear    - request to receiver to clear rx_data_rdy
//            we_control_rx_o - one-cycle strobe per captured word
//            rd_en_i         - consumer pop request
//            rd_data_o       - FIFO head, 0 when empty
//            empty_o/full_o  - occupancy flags
//            count_o         - occupancy 0..DEPTH
//            overflow_o      - sticky dropped-word flag
//            ovf_clr_i       - clears overflow_o
// Revision : 1.0 - initial release
// ============================================================================
module module_rx_buffer_ctrl #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int CLEAR_CYCLES = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     rx_data_rdy,
    input  logic [DATA_W-1:0]        rx_data_i,
    output logic                     new_rx_clear,
    output logic                     we_control_rx_o,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    input  logic                     ovf_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(CLEAR_CYCLES + 1);

    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [NW-1:0] C_CLR_LOAD = NW'(CLEAR_CYCLES);
    localparam logic [NW-1:0] C_CLR_LAST = NW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_CLEAR   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NW-1:0]     r_clr_cnt;
    logic [NW-1:0]     w_clr_cnt_nxt;
    logic              w_capture;
    logic              w_clear;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // ------------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_capture     = 1'b0;
        w_clear       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_data_rdy) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_capture     = 1'b1;
                w_clear       = 1'b1;
                w_clr_cnt_nxt = C_CLR_LOAD;
                w_state_nxt   = S_CLEAR;
            end
            S_CLEAR: begin
                w_clear = 1'b1;
                // The counter holds the number of clear cycles still owed,
                // including the current one.
                if (r_clr_cnt == C_CLR_LAST) begin
                    w_clr_cnt_nxt = '0;
                    w_state_nxt   = S_RELEASE;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt - 1'b1;
                end
            end
            S_RELEASE: begin
                // Wait for the receiver to drop its flag so a stuck flag
                // cannot cause a second capture of the same word.
                if (!rx_data_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign we_control_rx_o = w_capture;
    assign new_rx_clear    = w_clear;

    // ------------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------------
    assign w_pop  = rd_en_i && (r_count != '0);
    // A same-cycle pop frees the slot a push into a full FIFO needs.
    assign w_push = w_capture && ((r_count != C_DEPTH) || w_pop);
    assign w_drop = w_capture && !w_push;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Set has priority over clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign rd_data_o  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign count_o    = r_count;
    assign empty_o    = (r_count == '0);
    assign full_o     = (r_count == C_DEPTH);
    assign overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_module_rx_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_module_rx_buffer_ctrl
// Purpose  : Self-checking bench for module_rx_buffer_ctrl. A queue-based
//            model tracks FIFO contents and the sticky overflow flag; each
//            scenario task drives stimulus and compares against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_module_rx_buffer_ctrl;

    localparam int DATA_W       = 8;
    localparam int DEPTH        = 4;
    localparam int CLEAR_CYCLES = 3;
    localparam int CW           = $clog2(DEPTH) + 1;

    logic              clk_i       = 1'b0;
    logic              reset_i     = 1'b0;
    logic              rx_data_rdy = 1'b0;
    logic [DATA_W-1:0] rx_data_i   = '0;
    logic              rd_en_i     = 1'b0;
    logic              ovf_clr_i   = 1'b0;
    logic              new_rx_clear;
    logic              we_control_rx_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              empty_o;
    logic              full_o;
    logic [CW-1:0]     count_o;
    logic              overflow_o;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [DATA_W-1:0] q[$];
    bit                m_ovf = 1'b0;

    module_rx_buffer_ctrl #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .CLEAR_CYCLES (CLEAR_CYCLES)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .rx_data_rdy     (rx_data_rdy),
        .rx_data_i       (rx_data_i),
        .new_rx_clear    (new_rx_clear),
        .we_control_rx_o (we_control_rx_o),
        .rd_en_i         (rd_en_i),
        .rd_data_o       (rd_data_o),
        .empty_o         (empty_o),
        .full_o          (full_o),
        .count_o         (count_o),
        .overflow_o      (overflow_o),
        .ovf_clr_i       (ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------------------------------------------------------- stimulus
    task automatic apply_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        q.delete();
        m_ovf = 1'b0;
    endtask

    // One receiver word: flag high for one cycle, then a full clear/release
    // window. Returns strobe and clear counts seen over the whole sequence.
    task automatic do_capture(input logic [DATA_W-1:0] d, input bit pop_same,
                              output int n_clr, output int n_we,
                              output bit popped, output logic [DATA_W-1:0] pop_obs,
                              output logic [DATA_W-1:0] pop_exp);
        @(negedge clk_i);
        rx_data_rdy = 1'b1;
        rx_data_i   = d;
        @(negedge clk_i);
        n_clr       = int'(new_rx_clear);
        n_we        = int'(we_control_rx_o);
        rx_data_rdy = 1'b0;
        rd_en_i     = pop_same;
        pop_obs     = rd_data_o;
        popped      = 1'b0;
        pop_exp     = '0;
        if (pop_same && q.size() > 0) begin
            popped  = 1'b1;
            pop_exp = q.pop_front();
        end
        if (q.size() < DEPTH) q.push_back(d);
        else                  m_ovf = 1'b1;
        for (int i = 0; i < CLEAR_CYCLES + 2; i++) begin
            @(negedge clk_i);
            rd_en_i = 1'b0;
            n_clr += int'(new_rx_clear);
            n_we  += int'(we_control_rx_o);
        end
    endtask

    task automatic do_pop(output logic [DATA_W-1:0] obs, output logic [DATA_W-1:0] expv);
        @(negedge clk_i);
        obs     = rd_data_o;
        rd_en_i = 1'b1;
        expv    = (q.size() > 0) ? q.pop_front() : '0;
        @(negedge clk_i);
        rd_en_i = 1'b0;
    endtask

    task automatic do_ovf_clr();
        @(negedge clk_i);
        ovf_clr_i = 1'b1;
        @(negedge clk_i);
        ovf_clr_i = 1'b0;
        m_ovf = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset_i = 1'b0;
        @(negedge clk_i);
        total++; if (we_control_rx_o !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", we_control_rx_o); end
        total++; if (new_rx_clear !== 1'b0) begin bad++; $display("FAIL reset_clr: got %b want 0", new_rx_clear); end
        total++; if (count_o !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
        total++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin bad++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", empty_o, full_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        total++; if (rd_data_o !== '0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data_o); end
        reset_i = 1'b1;
        q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic test_single_word();
        int n_clr, n_we; bit p; logic [DATA_W-1:0] po, pe;
        do_capture(8'hA5, 1'b0, n_clr, n_we, p, po, pe);
        total++; if (n_we != 1) begin bad++; $display("FAIL single_strobe: got %0d want 1", n_we); end
        total++; if (n_clr != 1 + CLEAR_CYCLES) begin bad++; $display("FAIL single_clear_len: got %0d want %0d", n_clr, 1 + CLEAR_CYCLES); end
        total++; if (count_o !== CW'(1)) begin bad++; $display("FAIL single_count: got %0d want 1", count_o); end
        total++; if (rd_data_o !== 8'hA5) begin bad++; $display("FAIL single_head: got %h want a5", rd_data_o); end
        do_pop(po, pe);
        total++; if (po !== 8'hA5) begin bad++; $display("FAIL single_pop: got %h want a5", po); end
        total++; if (empty_o !== 1'b1 || rd_data_o !== '0) begin bad++; $display("FAIL single_empty: empty=%b data=%h want 1/00", empty_o, rd_data_o); end
    endtask

    task automatic test_stuck_flag();
        int n_clr = 0, n_we = 0; bit p; logic [DATA_W-1:0] po, pe;
        @(negedge clk_i);
        rx_data_rdy = 1'b1;
        rx_data_i   = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            n_clr += int'(new_rx_clear);
            n_we  += int'(we_control_rx_o);
        end
        rx_data_rdy = 1'b0;
        q.push_back(8'h5A);
        total++; if (n_we != 1) begin bad++; $display("FAIL stuck_strobe: got %0d want 1", n_we); end
        total++; if (n_clr != 1 + CLEAR_CYCLES) begin bad++; $display("FAIL stuck_clear_len: got %0d want %0d", n_clr, 1 + CLEAR_CYCLES); end
        total++; if (count_o !== CW'(1)) begin bad++; $display("FAIL stuck_count: got %0d want 1", count_o); end
        do_capture(8'h5B, 1'b0, n_clr, n_we, p, po, pe);
        total++; if (n_we != 1 || count_o !== CW'(2)) begin bad++; $display("FAIL stuck_next_capture: strobes=%0d count=%0d want 1/2", n_we, count_o); end
        do_pop(po, pe);
        total++; if (po !== 8'h5A) begin bad++; $display("FAIL stuck_pop0: got %h want 5a", po); end
        do_pop(po, pe);
        total++; if (po !== 8'h5B) begin bad++; $display("FAIL stuck_pop1: got %h want 5b", po); end
    endtask

    task automatic test_fill_overflow();
        int n_clr, n_we; bit p; logic [DATA_W-1:0] po, pe;
        for (int i = 1; i <= 5; i++) begin
            do_capture(DATA_W'(i), 1'b0, n_clr, n_we, p, po, pe);
            if (i == 4) begin
                total++; if (full_o !== 1'b1 || overflow_o !== 1'b0) begin bad++; $display("FAIL fill_full4: full=%b ovf=%b want 1/0", full_o, overflow_o); end
            end
        end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL fill_ovf: got %b want 1", overflow_o); end
        total++; if (count_o !== CW'(DEPTH)) begin bad++; $display("FAIL fill_count: got %0d want %0d", count_o, DEPTH); end
        for (int i = 1; i <= 4; i++) begin
            do_pop(po, pe);
            total++; if (po !== DATA_W'(i)) begin bad++; $display("FAIL fill_drain%0d: got %h want %h", i, po, DATA_W'(i)); end
        end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL fill_ovf_sticky: got %b want 1", overflow_o); end
        do_ovf_clr();
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL fill_ovf_clr: got %b want 0", overflow_o); end
    endtask

    task automatic test_full_pop();
        int n_clr, n_we; bit p; logic [DATA_W-1:0] po, pe;
        for (int i = 0; i < 4; i++) do_capture(DATA_W'(8'h10 + i), 1'b0, n_clr, n_we, p, po, pe);
        do_capture(8'h14, 1'b1, n_clr, n_we, p, po, pe);
        total++; if (po !== 8'h10) begin bad++; $display("FAIL fullpop_head: got %h want 10", po); end
        total++; if (overflow_o !== 1'b0 || count_o !== CW'(4)) begin bad++; $display("FAIL fullpop_state: ovf=%b count=%0d want 0/4", overflow_o, count_o); end
        for (int i = 1; i <= 4; i++) begin
            do_pop(po, pe);
            total++; if (po !== DATA_W'(8'h10 + i)) begin bad++; $display("FAIL fullpop_drain%0d: got %h want %h", i, po, DATA_W'(8'h10 + i)); end
        end
    endtask

    task automatic test_wrap();
        int n_clr, n_we; bit p; logic [DATA_W-1:0] po, pe;
        for (int i = 0; i < 10; i++) begin
            do_capture(DATA_W'(8'h20 + i), 1'($urandom_range(0, 1)), n_clr, n_we, p, po, pe);
            if (p) begin
                total++; if (po !== pe) begin bad++; $display("FAIL wrap_samepop%0d: got %h want %h", i, po, pe); end
            end
            if (q.size() > 3 || $urandom_range(0, 1) == 1) begin
                do_pop(po, pe);
                total++; if (po !== pe) begin bad++; $display("FAIL wrap_pop%0d: got %h want %h", i, po, pe); end
            end
            total++; if (count_o !== CW'(q.size()) || overflow_o !== 1'b0) begin bad++; $display("FAIL wrap_count%0d: count=%0d ovf=%b want %0d/0", i, count_o, overflow_o, q.size()); end
        end
        while (q.size() > 0) begin
            do_pop(po, pe);
            total++; if (po !== pe) begin bad++; $display("FAIL wrap_drain: got %h want %h", po, pe); end
        end
        do_pop(po, pe);
        total++; if (count_o !== '0 || empty_o !== 1'b1 || rd_data_o !== '0) begin bad++; $display("FAIL wrap_empty_rd: count=%0d empty=%b data=%h want 0/1/00", count_o, empty_o, rd_data_o); end
    endtask

    task automatic test_random();
        int n_clr, n_we; bit p; logic [DATA_W-1:0] po, pe, expd;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    do_capture(DATA_W'($urandom), 1'($urandom_range(0, 1)), n_clr, n_we, p, po, pe);
                    total++; if (n_we != 1 || n_clr != 1 + CLEAR_CYCLES || (p && po !== pe)) begin
                        bad++; $display("FAIL rand_capture%0d: strobes=%0d clears=%0d pop=%h want 1/%0d/%h", i, n_we, n_clr, po, 1 + CLEAR_CYCLES, pe);
                    end
                end
                2: begin
                    do_pop(po, pe);
                    total++; if (po !== pe) begin bad++; $display("FAIL rand_pop%0d: got %h want %h", i, po, pe); end
                end
                default: do_ovf_clr();
            endcase
            expd = (q.size() > 0) ? q[0] : '0;
            total++; if (count_o !== CW'(q.size()) || full_o !== (q.size() == DEPTH) || empty_o !== (q.size() == 0)
                        || overflow_o !== m_ovf || rd_data_o !== expd) begin
                bad++; $display("FAIL rand_state%0d: count=%0d full=%b empty=%b ovf=%b head=%h want %0d/%b/%b/%b/%h",
                                i, count_o, full_o, empty_o, overflow_o, rd_data_o,
                                q.size(), q.size() == DEPTH, q.size() == 0, m_ovf, expd);
            end
        end
    endtask

    task automatic test_async_reset();
        int n_clr, n_we; bit p; logic [DATA_W-1:0] po, pe;
        apply_reset();
        do_capture(8'h31, 1'b0, n_clr, n_we, p, po, pe);
        @(negedge clk_i);
        rx_data_rdy = 1'b1;
        rx_data_i   = 8'h32;
        @(negedge clk_i);
        rx_data_rdy = 1'b0;
        @(negedge clk_i);
        total++; if (new_rx_clear !== 1'b1 || count_o !== CW'(2)) begin bad++; $display("FAIL areset_pre: clr=%b count=%0d want 1/2", new_rx_clear, count_o); end
        #2 reset_i = 1'b0;
        #1;
        total++; if (new_rx_clear !== 1'b0 || we_control_rx_o !== 1'b0) begin bad++; $display("FAIL areset_fsm_out: clr=%b we=%b want 0/0", new_rx_clear, we_control_rx_o); end
        total++; if (count_o !== '0 || empty_o !== 1'b1 || rd_data_o !== '0 || overflow_o !== 1'b0) begin
            bad++; $display("FAIL areset_fifo: count=%0d empty=%b data=%h ovf=%b want 0/1/00/0", count_o, empty_o, rd_data_o, overflow_o);
        end
        q.delete();
        m_ovf = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        do_capture(8'h33, 1'b0, n_clr, n_we, p, po, pe);
        total++; if (n_we != 1 || n_clr != 1 + CLEAR_CYCLES || count_o !== CW'(1) || rd_data_o !== 8'h33) begin
            bad++; $display("FAIL areset_recover: strobes=%0d clears=%0d count=%0d head=%h want 1/%0d/1/33", n_we, n_clr, count_o, rd_data_o, 1 + CLEAR_CYCLES);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stuck_flag();
        test_fill_overflow();
        test_full_pop();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
